// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Adds or subtracts two W-bit operands (W = 4*NIBBLES) through a single
// 4-bit ripple-carry slice, one nibble per clock, least-significant first.
// The inter-nibble carry is kept in a register and fed back as the slice
// carry-in on the following cycle.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   start_i  request a new operation (sampled when not running)
//   sub_i    0 = add, 1 = subtract (A - B), sampled with start_i
//   cin_i    carry/borrow-in, sampled with start_i
//   a_i      operand A, sampled with start_i
//   b_i      operand B, sampled with start_i
//   busy_o   high while nibbles are being processed
//   done_o   one-cycle pulse after s_o/cout_o/ovf_o are updated
//   s_o      result register
//   cout_o   carry out of the MSB (for subtract, 1 = no borrow)
//   ovf_o    two's-complement signed overflow of the W-bit result
module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic         cin_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         ovf_o
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic [NIBBLES-1:0][3:0]    opa_q, opa_d;
  logic [NIBBLES-1:0][3:0]    opb_q, opb_d;
  logic [NIBBLES-1:0][3:0]    work_q, work_d;
  logic [W-1:0]               s_q, s_d;
  logic                       cout_q, cout_d;
  logic                       ovf_q, ovf_d;

  // The shared 4-bit slice: {C1,S4} = A4 + B4 + C0.
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [4:0] slice_sum;

  assign slice_a   = opa_q[idx_q];
  assign slice_b   = opb_q[idx_q];
  assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};

  logic accept;
  logic last_nibble;
  logic msb_carry_in;

  // A new operation may be taken from IDLE or, back-to-back, from FIN.
  assign accept      = start_i && (state_q != RUN);
  assign last_nibble = (idx_q == LAST_IDX);
  // Carry into bit 3 of the slice, recovered from its inputs and sum bit.
  // On the top nibble this is the carry into the operand MSB.
  assign msb_carry_in = slice_a[3] ^ slice_b[3] ^ slice_sum[3];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        work_d[idx_q] = slice_sum[3:0];
        carry_d       = slice_sum[4];
        if (last_nibble) begin
          // Result registers are loaded on the same edge as the last
          // nibble so they are already valid while DONE is high.
          state_d = FIN;
          idx_d   = '0;
          s_d     = work_d;
          cout_d  = slice_sum[4];
          ovf_d   = msb_carry_in ^ slice_sum[4];
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      opa_d   = a_i;
      // Subtraction as A + ~B + 1; CIN=1 then removes the +1 (borrow-in).
      opb_d   = sub_i ? ~b_i : b_i;
      carry_d = cin_i ^ sub_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == FIN);
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .sub_i   (sub),
    .cin_i   (cin),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .s_o     (s),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  // Issues one operation and waits (bounded) for DONE. lat is the number of
  // edges after the accept edge at which DONE was first seen (-1 = timeout).
  // On return the time is 1 ns after the edge that raised DONE.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tsub, input logic tcin, output int lat);
    @(posedge clk); #1;
    a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, s, cout, ovf} !== {2'b00, 16'h0000, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b s=%h cout=%b ovf=%b required all zero",
               busy, done, s, cout, ovf);
    end
    rst = 1'b0;
    $display("reset: busy=%b done=%b s=%h", busy, done, s);
  endtask

  task automatic test_add();
    int lat;
    // Check BUSY right after the accept edge, then the DONE latency/pulse.
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0004; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_busy busy=%b done=%b required busy=1 done=0", busy, done);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL add_latency done after %0d edges required 4 (5th cycle)", lat);
    end
    n_checks++;
    if (s !== 16'h0005 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result s=%h cout=%b ovf=%b busy=%b required s=0005 cout=0 ovf=0 busy=0",
               s, cout, ovf, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || s !== 16'h0005) begin
      n_fail++;
      $display("FAIL add_pulse done=%b s=%h required done=0 s=0005", done, s);
    end
    $display("add 0001+0004: s=%h cout=%b ovf=%b lat=%0d", s, cout, ovf, lat);
  endtask

  task automatic test_wrap();
    int lat;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_ffff lat=%0d s=%h cout=%b ovf=%b required lat=4 s=0000 cout=1 ovf=0",
               lat, s, cout, ovf);
    end
    $display("add FFFF+0001: s=%h cout=%b ovf=%b", s, cout, ovf);
    do_op(16'h5555, 16'hAAAA, 1'b0, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_cin lat=%0d s=%h cout=%b ovf=%b required lat=4 s=0000 cout=1 ovf=0",
               lat, s, cout, ovf);
    end
    $display("add 5555+AAAA+1: s=%h cout=%b ovf=%b", s, cout, ovf);
  endtask

  task automatic test_overflow();
    int lat;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos lat=%0d s=%h cout=%b ovf=%b required lat=4 s=8000 cout=0 ovf=1",
               lat, s, cout, ovf);
    end
    $display("add 7FFF+0001: s=%h cout=%b ovf=%b", s, cout, ovf);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg lat=%0d s=%h cout=%b ovf=%b required lat=4 s=0000 cout=1 ovf=1",
               lat, s, cout, ovf);
    end
    $display("add 8000+8000: s=%h cout=%b ovf=%b", s, cout, ovf);
  endtask

  task automatic test_subtract();
    int lat;
    do_op(16'h0005, 16'h000A, 1'b1, 1'b0, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'hFFFB || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_plain lat=%0d s=%h cout=%b ovf=%b required lat=4 s=FFFB cout=0 ovf=0",
               lat, s, cout, ovf);
    end
    $display("sub 0005-000A: s=%h cout=%b ovf=%b", s, cout, ovf);
    do_op(16'h0005, 16'h000A, 1'b1, 1'b1, lat);
    n_checks++;
    if (lat !== 4 || s !== 16'hFFFA || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow lat=%0d s=%h cout=%b ovf=%b required lat=4 s=FFFA cout=0 ovf=0",
               lat, s, cout, ovf);
    end
    $display("sub 0005-000A-1: s=%h cout=%b ovf=%b", s, cout, ovf);
  endtask

  task automatic test_interference();
    int lat;
    int done_seen;
    // START pulsed mid-RUN with other operands must be ignored.
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0004; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // accept edge
    start = 1'b0;
    @(posedge clk); #1;          // nibble 0 processed
    a = 16'h1111; b = 16'h2222; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;          // sampled while RUN
    start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 4 || s !== 16'h0005 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start lat=%0d s=%h cout=%b ovf=%b required lat=4 s=0005 cout=0 ovf=0",
               lat, s, cout, ovf);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_queue busy=%b done=%b required busy=0 done=0", busy, done);
    end
    $display("interference: s=%h lat=%0d", s, lat);

    // Reset sampled on the edge that processes the 2nd nibble.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // accept edge
    start = 1'b0;
    @(posedge clk); #1;          // nibble 0
    rst = 1'b1;
    @(posedge clk); #1;          // nibble-1 edge sees reset
    rst = 1'b0;
    n_checks++;
    if ({busy, done, s, cout, ovf} !== {2'b00, 16'h0000, 2'b00}) begin
      n_fail++;
      $display("FAIL abort_state busy=%b done=%b s=%h cout=%b ovf=%b required all zero",
               busy, done, s, cout, ovf);
    end
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0 || s !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_nodone active_cycles=%0d s=%h required 0 and s=0000", done_seen, s);
    end
    $display("abort: busy=%b done=%b s=%h", busy, done, s);
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int hold_bad;
    first = -1; second = -1; hold_bad = 0;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0004; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;          // accept edge of op 1
    a = 16'h1234; b = 16'h1111;  // START stays high
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) begin
          first = t;
          n_checks++;
          if (s !== 16'h0005) begin
            n_fail++;
            $display("FAIL b2b_first s=%h required 0005", s);
          end
        end else begin
          second = t;
          start = 1'b0;
          break;
        end
      end else if (first >= 0 && s !== 16'h0005) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (first !== 4 || second !== 9) begin
      n_fail++;
      $display("FAIL b2b_timing done at %0d,%0d required 4,9", first, second);
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold s changed early in %0d cycles required 0", hold_bad);
    end
    n_checks++;
    if (s !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second s=%h cout=%b ovf=%b required s=2345 cout=0 ovf=0", s, cout, ovf);
    end
    $display("back-to-back: done at %0d,%0d s=%h", first, second, s);
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_overflow();
    test_subtract();
    test_interference();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
